// File: rtl/gather8_pkg.sv
// Shared constants and types for the 8-sample gather front end.
package gather8_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_TAPS = 8;
  localparam int CNT_W    = 3;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [NUM_TAPS-1:0]   frame_t;

  typedef enum logic {
    FILL,
    DONE
  } state_t;

endpackage

// File: rtl/gather8_bank.sv
// NUM_TAPS-entry register bank: indexed write port, all entries readable in parallel.
module gather8_bank
  import gather8_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         we_i,
  input  logic [CNT_W-1:0]             waddr_i,
  input  logic [DW-1:0]                wdata_i,
  output logic [NUM_TAPS-1:0][DW-1:0]  rdata_o
);

  logic [NUM_TAPS-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q;

endmodule

// File: rtl/sample_gather8.sv
// Packs a serial sample stream into 8-wide frames a..h (a = oldest).
// SAMPLE_GATHER8_SLIDING_EN selects a sliding-window variant instead of block framing.
module sample_gather8
  import gather8_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SA_W   = 8,
  parameter int SHIFT  = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] a,
  output logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] c,
  output logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] e,
  output logic signed [DATA_W-1:0] f,
  output logic signed [DATA_W-1:0] g,
  output logic signed [DATA_W-1:0] h,
  output logic [SA_W-1:0]          sa,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [NUM_TAPS-1:0][DATA_W-1:0] out_q, out_d;
  logic                            ov_q, ov_d;
  logic                            acc;

  assign sa = SA_W'(SHIFT);

`ifdef SAMPLE_GATHER8_SLIDING_EN
  logic [CNT_W:0] cnt_q, cnt_d;

  assign in_ready = !Rst && (!ov_q || out_ready);
  assign acc      = in_valid && in_ready;

  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    ov_d  = ov_q && !out_ready;
    if (acc) begin
      out_d = {in_data, out_q[NUM_TAPS-1:1]};
      cnt_d = (cnt_q == (CNT_W+1)'(NUM_TAPS)) ? cnt_q : cnt_q + 1'b1;
      ov_d  = (cnt_q >= (CNT_W+1)'(NUM_TAPS-1));
    end
  end
`else
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_TAPS-1:0][DATA_W-1:0] fill_w;
  logic                            last;
  state_t                          state;

  gather8_bank #(
    .DW (DATA_W)
  ) u_fill (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .we_i    (acc),
    .waddr_i (cnt_q),
    .wdata_i (in_data),
    .rdata_o (fill_w)
  );

  assign last     = (cnt_q == CNT_W'(NUM_TAPS-1));
  // Only the 8th sample needs the output bank free; earlier ones land in the fill bank.
  assign in_ready = !Rst && !(last && ov_q && !out_ready);
  assign acc      = in_valid && in_ready;

  always_comb begin
    state = (acc && last) ? DONE : FILL;
    cnt_d = cnt_q;
    out_d = out_q;
    ov_d  = ov_q && !out_ready;
    if (acc) begin
      cnt_d = cnt_q + 1'b1;
    end
    case (state)
      DONE: begin
        out_d               = fill_w;
        out_d[NUM_TAPS-1]   = in_data;
        ov_d                = 1'b1;
      end
      default: ;
    endcase
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_q <= '0;
      ov_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
    end
  end

  assign a         = out_q[0];
  assign b         = out_q[1];
  assign c         = out_q[2];
  assign d         = out_q[3];
  assign e         = out_q[4];
  assign f         = out_q[5];
  assign g         = out_q[6];
  assign h         = out_q[7];
  assign out_valid = ov_q;

endmodule

// File: tb/tb_sample_gather8.sv
// Scoreboard bench for sample_gather8 in block mode (SAMPLE_GATHER8_SLIDING_EN undefined).
module tb_sample_gather8;

  typedef logic [15:0] frame_t [8];

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [7:0]  sa;
  logic        out_valid;
  logic        out_ready;

  int unsigned errors = 0;
  int unsigned checks = 0;

  frame_t      exp_q[$];
  logic [15:0] part[$];
  logic        was_rst = 1'b1;

  always #5 Clk = ~Clk;

  sample_gather8 #(
    .DATA_W (16),
    .SA_W   (8),
    .SHIFT  (1)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .sa        (sa),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reference model is a queue of completed frames plus a list of pending samples.
  always @(negedge Clk) begin
    frame_t cur;
    logic   exp_rdy;
    cur     = '{a, b, c, d, e, f, g, h};
    exp_rdy = !Rst && !(part.size() == 7 && exp_q.size() > 0 && !out_ready);
    chk("sa", 32'(sa), 32'd1);
    if (Rst) begin
      chk("in_ready_rst", 32'(in_ready), 32'd0);
      exp_q.delete();
      part.delete();
    end else begin
      if (was_rst) begin
        chk("reset_data", 32'(a | b | c | d | e | f | g | h), 32'd0);
      end
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (out_valid && exp_q.size() > 0) begin
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("slot%0d", i), 32'(cur[i]), 32'(exp_q[0][i]));
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        part.push_back(in_data);
        if (part.size() == 8) begin
          frame_t fr;
          for (int i = 0; i < 8; i++) fr[i] = part[i];
          exp_q.push_back(fr);
          part.delete();
        end
      end
    end
    was_rst = Rst;
  end

  task automatic idle(input int n, input logic ordy);
    in_valid  = 1'b0;
    out_ready = ordy;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Hold a sample on the input until accepted; out_ready is forced high after rel stalled cycles.
  task automatic send(input logic [15:0] dv, input logic ordy, input int rel);
    logic acc;
    acc       = 1'b0;
    in_valid  = 1'b1;
    in_data   = dv;
    out_ready = ordy;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk);
      acc = in_ready;
      @(posedge Clk);
      #1;
      if (acc) break;
      if (n + 1 >= rel) out_ready = 1'b1;
    end
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got in_ready=0 expected accept of %0h", dv);
    end
  endtask

  initial begin
    logic [15:0] sv [8];
    sv = '{16'h8000, 16'h7fff, 16'hffff, 16'h0000, 16'h0005, 16'hfffb, 16'h0064, 16'hff9c};
    Rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    idle(2, 1'b1);

    for (int i = 1; i <= 8; i++) send(16'(i), 1'b1, 1000);
    idle(3, 1'b1);

    for (int i = 0; i < 8; i++) send(sv[i], 1'b1, 1000);
    idle(3, 1'b1);

    for (int i = 1; i <= 15; i++) send(16'(100 + i), 1'b0, 1000);
    send(16'd116, 1'b0, 3);
    idle(3, 1'b1);

    for (int i = 1; i <= 24; i++) send(16'(i), 1'b1, 1000);
    idle(3, 1'b1);

    for (int i = 1; i <= 5; i++) send(16'(50 + i), 1'b1, 1000);
    in_valid = 1'b0;
    Rst      = 1'b1;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    Rst = 1'b0;
    idle(1, 1'b1);
    for (int i = 10; i <= 17; i++) send(16'(i), 1'b1, 1000);
    idle(3, 1'b1);

    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge Clk);
      #1;
    end
    idle(4, 1'b1);

    @(negedge Clk);
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
